// File: rtl/uart_relay.sv
// uart_relay
// Receives UART bytes, buffers them in a FIFO and retransmits them. Each
// byte popped from the FIFO passes either straight through or through a
// Hamming(7,4) encode / optional single-bit injection / decode round trip
// before it is loaded into the transmitter.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   reset         : synchronous active-high reset
//   bit_in        : asynchronous UART RX line (idle high)
//   bit_out       : UART TX line (idle high)
//   ecc_en        : 1 = Hamming round-trip path, 0 = pass-through (sampled at pop)
//   tx_hold       : blocks new pops while high; a frame in progress completes
//   led_bus       : last byte loaded into the transmitter
//   fifo_count    : current FIFO occupancy
//   overflow      : sticky, a good RX byte was dropped on a full FIFO
//   err_count     : saturating count of RX framing / parity errors
//   tx_busy       : high from the pop cycle through the last stop-bit cycle
//   ecc_corrected : pulse in the pop cycle when either decoder syndrome is nonzero
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a synchronised high-to-low transition
//   RX_START  | half-bit wait, then confirm start bit is still low
//   RX_DATA   | sample 8 data bits LSB first at mid-bit
//   RX_PARITY | sample even parity bit (PARITY_EN only)
//   RX_STOP   | sample stop bit; push good byte or count error
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, a pop may load a new frame
//   TX_SEND   | shifting start, data, optional parity and stop bits

module uart_relay #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int INJ_POS      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_in,
  output logic                          bit_out,
  input  logic                          ecc_en,
  input  logic                          tx_hold,
  output logic [7:0]                    led_bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    err_count,
  output logic                          tx_busy,
  output logic                          ecc_corrected
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  // Injection mask over codeword positions 1..7; position 0 means none.
  localparam logic [7:0] INJ_ONEHOT = 8'(1 << INJ_POS);
  localparam logic [6:0] INJ_MASK   = INJ_ONEHOT[7:1];

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Codeword bit k holds position k+1: {d3,d2,d1,p4,d0,p2,p1}.
  function automatic logic [6:0] ham_enc(input logic [3:0] d);
    ham_enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
               d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [2:0] ham_syn(input logic [6:0] c);
    ham_syn = {c[3] ^ c[4] ^ c[5] ^ c[6],
               c[1] ^ c[2] ^ c[5] ^ c[6],
               c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic logic [3:0] ham_fix(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] f;
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    ham_fix = {f[6], f[5], f[4], f[2]};
  endfunction

  // RX
  logic          sync1, sync2, sync_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_par;
  logic          push_req;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic [7:0]    head;

  // TX
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;
  logic [9:0]    tx_shift;

  // Transform
  logic [6:0]    cw_lo, cw_hi;
  logic [2:0]    syn_lo, syn_hi;
  logic [7:0]    tx_byte;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  // count is registered, so a byte pushed into an empty FIFO is not visible
  // to pop until the following cycle.
  assign pop   = !reset && (tx_state == TX_IDLE) && (count != '0) && !tx_hold;
  assign push  = push_req && (!full || pop);
  assign head  = mem[rd_ptr];

  assign fifo_count    = count;
  assign tx_busy       = (tx_state == TX_SEND) || pop;
  assign ecc_corrected = pop && ecc_en && ((syn_lo != 3'd0) || (syn_hi != 3'd0));

  always_comb begin
    cw_lo   = ham_enc(head[3:0]) ^ INJ_MASK;
    cw_hi   = ham_enc(head[7:4]) ^ INJ_MASK;
    syn_lo  = ham_syn(cw_lo);
    syn_hi  = ham_syn(cw_hi);
    tx_byte = head;
    if (ecc_en) tx_byte = {ham_fix(cw_hi, syn_hi), ham_fix(cw_lo, syn_lo)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      push_req  <= 1'b0;
      err_count <= '0;
    end else begin
      sync1     <= bit_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      push_req  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (sync_prev && !sync2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            // A line already back high is a glitch, not a start bit.
            if (sync2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {sync2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt == '0) begin
            rx_par   <= sync2;
            rx_state <= RX_STOP;
            rx_cnt   <= BIT_LAST;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            // Back to idle at mid-stop; the line is high so no false start.
            rx_state <= RX_IDLE;
            if (sync2 && ((PARITY_EN == 0) || (rx_par == ^rx_shift))) begin
              push_req <= 1'b1;
            end else if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      bit_out  <= 1'b1;
      tx_cnt   <= '0;
      tx_left  <= '0;
      tx_shift <= '1;
      led_bus  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_state <= TX_SEND;
            bit_out  <= 1'b0;
            tx_cnt   <= BIT_LAST;
            // Bits still to send after the start bit: data, parity?, stop.
            tx_left  <= (PARITY_EN != 0) ? 4'd10 : 4'd9;
            tx_shift <= {1'b1, (PARITY_EN != 0) ? ^tx_byte : 1'b1, tx_byte};
            led_bus  <= tx_byte;
          end
        end
        TX_SEND: begin
          if (tx_cnt == '0) begin
            if (tx_left == 4'd0) begin
              tx_state <= TX_IDLE;
              bit_out  <= 1'b1;
            end else begin
              bit_out  <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_left  <= tx_left - 4'd1;
              tx_cnt   <= BIT_LAST;
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
